// File: rtl/sb_keypad_ctrl.sv
// sb_keypad_ctrl: 4x4 matrix keypad scanner with debounce and entry FSM.
// Column c is driven low for SCAN_DIV clocks; synchronised rows are sampled on
// the last clock of each column. A full scan yields a single scan code or
// "none". Debounced codes drive an entry FSM that produces one-cycle strobes
// for the float converter (key_vld/state/but_num) and the operator unit.
module sb_keypad_ctrl #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  input  logic       clr,
  output logic       key_vld,
  output logic [1:0] state,
  output logic [3:0] but_num,
  output logic       op_vld,
  output logic [1:0] op,
  output logic       eq_vld
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_DONE  = 2'd2,
    S_REARM = 2'd3
  } fsm_t;

  // Digit value carried on but_num for a scan code; the dot maps to 4'hF.
  function automatic logic [3:0] key_value(input logic [3:0] code);
    case (code)
      4'd0:    key_value = 4'd1;
      4'd1:    key_value = 4'd2;
      4'd2:    key_value = 4'd3;
      4'd4:    key_value = 4'd4;
      4'd5:    key_value = 4'd5;
      4'd6:    key_value = 4'd6;
      4'd8:    key_value = 4'd7;
      4'd9:    key_value = 4'd8;
      4'd10:   key_value = 4'd9;
      4'd12:   key_value = 4'hF;
      4'd13:   key_value = 4'd0;
      default: key_value = 4'd0;
    endcase
  endfunction

  // Synchroniser and edge-detect registers
  logic [3:0] r_row_m, r_row_s;
  logic       r_clr_m, r_clr_s, r_clr_d;
  // Scan timing and per-scan accumulator
  logic [DW-1:0] r_div;
  logic [1:0]    r_col;
  logic [1:0]    r_hits;   // 0: nothing seen, 1: exactly one key, 2: several
  logic [3:0]    r_code;
  // Debounce tracking
  logic          r_last_vld;
  logic [3:0]    r_last_code;
  logic [CW-1:0] r_match;
  logic [CW-1:0] r_none;
  logic          r_armed;
  // Entry FSM
  fsm_t          r_fsm;
  logic          r_dot;
  logic [3:0]    r_frac;
  logic [3:0]    r_pend;

  logic          w_sample, w_scan_end, w_scan_hit, w_accept, w_clr_rise;
  logic [2:0]    w_low_cnt;
  logic [1:0]    w_low_row;
  logic [1:0]    w_hits;
  logic [3:0]    w_code;
  logic [CW-1:0] w_match_next;
  logic          w_is_op, w_is_eq, w_is_dot, w_is_num;
  logic [3:0]    w_val;

  assign w_sample   = (r_div == DW'(SCAN_DIV - 1));
  assign w_scan_end = w_sample && (r_col == 2'd3);
  assign w_scan_hit = (w_hits == 2'd1);
  assign w_clr_rise = r_clr_s && !r_clr_d;

  assign w_is_op  = (w_code[1:0] == 2'b11);
  assign w_is_eq  = (w_code == 4'd14);
  assign w_is_dot = (w_code == 4'd12);
  assign w_is_num = !w_is_op && !w_is_eq;
  assign w_val    = key_value(w_code);

  // Two-flop synchronisers for rows and clear, plus clear edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_m <= 4'hF;
      r_row_s <= 4'hF;
      r_clr_m <= 1'b0;
      r_clr_s <= 1'b0;
      r_clr_d <= 1'b0;
    end else begin
      r_row_m <= row_n;
      r_row_s <= r_row_m;
      r_clr_m <= clr;
      r_clr_s <= r_clr_m;
      r_clr_d <= r_clr_s;
    end
  end

  // Count low rows in the current sample and remember which row was low.
  always_comb begin
    w_low_cnt = 3'd0;
    w_low_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      w_low_cnt = w_low_cnt + {2'b00, ~r_row_s[r]};
      if (!r_row_s[r]) begin
        w_low_row = 2'(r);
      end else begin
        w_low_row = w_low_row;
      end
    end
  end

  // Fold this column's sample into the running scan result.
  always_comb begin
    w_hits = r_hits;
    w_code = r_code;
    if (w_low_cnt == 3'd1) begin
      if (r_hits == 2'd0) begin
        w_hits = 2'd1;
        w_code = {w_low_row, r_col};
      end else begin
        w_hits = 2'd2;
      end
    end else if (w_low_cnt != 3'd0) begin
      w_hits = 2'd2;
    end else begin
      w_hits = r_hits;
    end
  end

  // Length of the identical-code run including this scan.
  always_comb begin
    if (r_last_vld && (r_last_code == w_code)) begin
      w_match_next = r_match + CW'(1);
    end else begin
      w_match_next = CW'(1);
    end
  end

  assign w_accept = w_scan_end && w_scan_hit && r_armed &&
                    (w_match_next == CW'(DEBOUNCE));

  // Column timing, column drive and scan accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_col  <= 2'd0;
      col_n  <= 4'b1110;
      r_hits <= 2'd0;
      r_code <= 4'd0;
    end else if (w_sample) begin
      r_div <= '0;
      r_col <= r_col + 2'd1;
      col_n <= {col_n[2:0], col_n[3]};
      if (r_col == 2'd3) begin
        r_hits <= 2'd0;
        r_code <= 4'd0;
      end else begin
        r_hits <= w_hits;
        r_code <= w_code;
      end
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Debounce: accept after DEBOUNCE identical scans, re-arm after DEBOUNCE empty scans.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_vld  <= 1'b0;
      r_last_code <= 4'd0;
      r_match     <= '0;
      r_none      <= '0;
      r_armed     <= 1'b1;
    end else if (w_scan_end) begin
      if (w_scan_hit) begin
        r_last_vld  <= 1'b1;
        r_last_code <= w_code;
        r_none      <= '0;
        if (w_accept) begin
          r_armed <= 1'b0;
          r_match <= '0;
        end else if (r_armed) begin
          r_match <= w_match_next;
        end else begin
          r_match <= '0;
        end
      end else begin
        r_last_vld <= 1'b0;
        r_match    <= '0;
        if (r_armed) begin
          r_none <= '0;
        end else if ((r_none + CW'(1)) >= CW'(DEBOUNCE)) begin
          r_armed <= 1'b1;
          r_none  <= '0;
        end else begin
          r_none <= r_none + CW'(1);
        end
      end
    end
  end

  // Entry FSM with registered strobes; clear outranks a same-cycle key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_dot   <= 1'b0;
      r_frac  <= 4'd0;
      r_pend  <= 4'd0;
      key_vld <= 1'b0;
      state   <= 2'b00;
      but_num <= 4'd0;
      op_vld  <= 1'b0;
      op      <= 2'b00;
      eq_vld  <= 1'b0;
    end else begin
      key_vld <= 1'b0;
      op_vld  <= 1'b0;
      eq_vld  <= 1'b0;
      if (w_clr_rise) begin
        r_fsm   <= S_IDLE;
        r_dot   <= 1'b0;
        r_frac  <= 4'd0;
        key_vld <= 1'b1;
        state   <= 2'b00;
      end else if (r_fsm == S_REARM) begin
        key_vld <= 1'b1;
        state   <= 2'b01;
        but_num <= r_pend;
        r_fsm   <= S_ENTRY;
      end else if (w_accept) begin
        case (r_fsm)
          S_IDLE: begin
            if (w_is_num) begin
              r_fsm   <= S_ENTRY;
              key_vld <= 1'b1;
              state   <= 2'b01;
              but_num <= w_val;
              r_dot   <= w_is_dot;
              r_frac  <= 4'd0;
            end else begin
              op_vld <= w_is_op;
              eq_vld <= w_is_eq;
              if (w_is_op) op <= w_code[3:2];
            end
          end
          S_ENTRY: begin
            if (w_is_dot) begin
              if (!r_dot) begin
                key_vld <= 1'b1;
                state   <= 2'b01;
                but_num <= 4'hF;
                r_dot   <= 1'b1;
              end
            end else if (w_is_num) begin
              if (!r_dot) begin
                key_vld <= 1'b1;
                state   <= 2'b01;
                but_num <= w_val;
              end else if (r_frac < 4'd8) begin
                key_vld <= 1'b1;
                state   <= 2'b01;
                but_num <= w_val;
                r_frac  <= r_frac + 4'd1;
              end
            end else begin
              r_fsm   <= S_DONE;
              key_vld <= 1'b1;
              state   <= 2'b11;
              op_vld  <= w_is_op;
              eq_vld  <= w_is_eq;
              if (w_is_op) op <= w_code[3:2];
            end
          end
          S_DONE: begin
            if (w_is_num) begin
              r_fsm   <= S_REARM;
              key_vld <= 1'b1;
              state   <= 2'b00;
              r_pend  <= w_val;
              r_dot   <= w_is_dot;
              r_frac  <= 4'd0;
            end else begin
              op_vld <= w_is_op;
              eq_vld <= w_is_eq;
              if (w_is_op) op <= w_code[3:2];
            end
          end
          default: r_fsm <= S_IDLE;
        endcase
      end
    end
  end

endmodule
